// File: rtl/trdb_packet_deframer.sv
// Receive-side deframer for the trace packet link: turns a header+payload byte
// stream back into decoded encoder packets on a registered valid/ready output.
package trdb_deframer_pkg;
  typedef enum logic [1:0] {
    F_OPT_EXT    = 2'd0,
    F_ADDR_ONLY  = 2'd1,
    F_DIFF_DELTA = 2'd2,
    F_SYNC       = 2'd3
  } trdb_format_e;

  typedef enum logic [1:0] {
    SF_START   = 2'd0,
    SF_TRAP    = 2'd1,
    SF_CONTEXT = 2'd2,
    SF_SUPPORT = 2'd3
  } trdb_f_sync_subformat_e;
endpackage

module trdb_packet_deframer
  import trdb_deframer_pkg::*;
#(
  parameter int MAX_PAYLOAD_BYTES = 16,
  parameter int TIMEOUT_CYCLES    = 64,
  parameter int THADDR_POS        = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           byte_valid_i,
  input  logic [7:0]                     byte_i,
  output logic                           byte_ready_o,
  output logic                           pkt_valid_o,
  input  logic                           pkt_ready_i,
  output trdb_format_e                   packet_format_o,
  output trdb_f_sync_subformat_e         packet_f_sync_subformat_o,
  output logic                           thaddr_o,
  output logic [7:0]                     pkt_len_o,
  output logic [8*MAX_PAYLOAD_BYTES-1:0] payload_o,
  output logic                           err_len_o,
  output logic                           err_timeout_o
);

  localparam int PW = 8 * MAX_PAYLOAD_BYTES;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  // Handshakes: a byte moves on any edge where byte_valid_i && byte_ready_o,
  // a packet moves on any edge where pkt_valid_o && pkt_ready_i; neither ready
  // depends combinationally on the opposite valid.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_OUT     = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [7:0]             len_q, len_d;
  logic [7:0]             idx_q, idx_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [PW-1:0]          payload_q, payload_d;
  trdb_format_e           fmt_q, fmt_d;
  trdb_f_sync_subformat_e sub_q, sub_d;
  logic                   thaddr_q, thaddr_d;
  logic                   err_len_q, err_len_d;
  logic                   err_tmo_q, err_tmo_d;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    payload_d = payload_q;
    fmt_d     = fmt_q;
    sub_d     = sub_q;
    thaddr_d  = thaddr_q;
    err_len_d = 1'b0;
    err_tmo_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (byte_valid_i) begin
          if (byte_i == 8'd0 || byte_i > 8'(MAX_PAYLOAD_BYTES)) begin
            err_len_d = 1'b1;
          end else begin
            len_d     = byte_i;
            payload_d = '0;
            idx_d     = 8'd0;
            tmo_d     = '0;
            state_d   = ST_PAYLOAD;
          end
        end
      end

      ST_PAYLOAD: begin
        if (byte_valid_i) begin
          for (int k = 0; k < MAX_PAYLOAD_BYTES; k++) begin
            if (idx_q == 8'(k)) payload_d[8*k +: 8] = byte_i;
          end
          idx_d = idx_q + 8'd1;
          tmo_d = '0;
          if (idx_q == len_q - 8'd1) begin
            // Decode from the just-completed payload so the packet fields are
            // registered together with the final byte.
            state_d  = ST_OUT;
            fmt_d    = trdb_format_e'(payload_d[1:0]);
            sub_d    = SF_START;
            thaddr_d = 1'b0;
            if (fmt_d == F_SYNC) begin
              sub_d = trdb_f_sync_subformat_e'(payload_d[3:2]);
              if (sub_d == SF_TRAP) thaddr_d = payload_d[THADDR_POS];
            end
          end
        end else begin
          if (tmo_q != '1) tmo_d = tmo_q + 1'b1;
          if (TIMEOUT_CYCLES != 0 && tmo_d == TW'(TIMEOUT_CYCLES)) begin
            err_tmo_d = 1'b1;
            payload_d = '0;
            len_d     = 8'd0;
            idx_d     = 8'd0;
            tmo_d     = '0;
            state_d   = ST_IDLE;
          end
        end
      end

      ST_OUT: begin
        if (pkt_ready_i) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      len_q     <= 8'd0;
      idx_q     <= 8'd0;
      tmo_q     <= '0;
      payload_q <= '0;
      fmt_q     <= F_OPT_EXT;
      sub_q     <= SF_START;
      thaddr_q  <= 1'b0;
      err_len_q <= 1'b0;
      err_tmo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      payload_q <= payload_d;
      fmt_q     <= fmt_d;
      sub_q     <= sub_d;
      thaddr_q  <= thaddr_d;
      err_len_q <= err_len_d;
      err_tmo_q <= err_tmo_d;
    end
  end

  assign byte_ready_o              = (state_q == ST_IDLE) || (state_q == ST_PAYLOAD);
  assign pkt_valid_o               = (state_q == ST_OUT);
  assign packet_format_o           = fmt_q;
  assign packet_f_sync_subformat_o = sub_q;
  assign thaddr_o                  = thaddr_q;
  assign pkt_len_o                 = len_q;
  assign payload_o                 = payload_q;
  assign err_len_o                 = err_len_q;
  assign err_timeout_o             = err_tmo_q;

endmodule
